// File: rtl/tdm_mux_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_pkg : shared mode constants and FSM state type for tdm_mux_scanner |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Wide enough for the largest legal dwell (65535 cycles)
  localparam int DWELL_CNT_W = 16;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SCAN_START = 2'd1,
    SCAN       = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tdm_mux_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_mux_scanner_if : source-side inputs and registered mux outputs     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface tdm_mux_scanner_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) ();

  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [CHANNELS-1:0]       ch_en;
  logic                      hold;
  logic [WIDTH-1:0]          dout;
  logic [SEL_W-1:0]          dout_ch;
  logic                      dout_valid;
  logic                      scan_wrap;

  modport master (
    output mode, sel_in, din, ch_en, hold,
    input  dout, dout_ch, dout_valid, scan_wrap
  );

  modport slave (
    input  mode, sel_in, din, ch_en, hold,
    output dout, dout_ch, dout_valid, scan_wrap
  );

endinterface
`default_nettype wire

// File: rtl/tdm_mux_scanner_next_ch_finder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_next_ch_finder : rotating priority encoder, next enabled channel  |
// | strictly above ptr; wrap set when the search passes CHANNELS-1.       |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module mux_next_ch_finder
  import mux_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] ch_en,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    next_ch,
  output logic                wrap,
  output logic                any_enabled
);

  always_comb begin
    int               w_idx;
    logic [SEL_W-1:0] w_idx_s;
    next_ch     = ptr;
    wrap        = 1'b0;
    any_enabled = 1'b0;
    w_idx       = 0;
    w_idx_s     = '0;
    // Offset CHANNELS lands back on ptr itself, covering the single-channel case
    for (int i = 1; i <= CHANNELS; i++) begin
      w_idx = int'(ptr) + i;
      if (w_idx >= CHANNELS) begin
        w_idx = w_idx - CHANNELS;
      end
      w_idx_s = SEL_W'(w_idx);
      if (!any_enabled && ch_en[w_idx_s]) begin
        any_enabled = 1'b1;
        next_ch     = w_idx_s;
        wrap        = (int'(ptr) + i >= CHANNELS);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdm_mux_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_mux_scanner : registered N:1 word mux, manual select or dwell scan |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tdm_mux_scanner
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 4
) (
  input logic               clk,
  input logic               rst,
  tdm_mux_scanner_if.slave  bus
);

  localparam int                     c_slots      = 1 << SEL_W;
  localparam logic [SEL_W-1:0]       c_top_ch     = SEL_W'(CHANNELS - 1);
  localparam logic [DWELL_CNT_W-1:0] c_dwell_last = DWELL_CNT_W'(DWELL - 1);

  state_e                 r_state;
  logic [SEL_W-1:0]       r_ptr;
  logic [DWELL_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]       r_dout;
  logic [SEL_W-1:0]       r_dout_ch;
  logic                   r_valid;
  logic                   r_wrap;

  logic [WIDTH-1:0] w_words [c_slots];
  logic [c_slots-1:0] w_en_pad;
  logic [SEL_W-1:0] w_next;
  logic             w_wrap;
  logic             w_any;
  logic [SEL_W-1:0] w_lo_next;
  logic             w_lo_wrap;
  logic             w_lo_any;
  logic [WIDTH-1:0] w_man_dout;
  logic             w_man_valid;
  logic             w_ptr_en;

  // Select space padded to a power of two; unused slots read as disabled zero
  generate
    for (genvar k = 0; k < c_slots; k++) begin : g_slot
      if (k < CHANNELS) begin : g_real
        assign w_words[k]  = bus.din[k*WIDTH +: WIDTH];
        assign w_en_pad[k] = bus.ch_en[k];
      end else begin : g_pad
        assign w_words[k]  = '0;
        assign w_en_pad[k] = 1'b0;
      end
    end
  endgenerate

  assign w_man_dout  = w_words[bus.sel_in];
  assign w_man_valid = w_en_pad[bus.sel_in];
  assign w_ptr_en    = w_en_pad[r_ptr];

  mux_next_ch_finder #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_next (
    .ch_en       (bus.ch_en),
    .ptr         (r_ptr),
    .next_ch     (w_next),
    .wrap        (w_wrap),
    .any_enabled (w_any)
  );

  // Seeding the search at the top index yields the lowest enabled channel
  mux_next_ch_finder #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_lowest (
    .ch_en       (bus.ch_en),
    .ptr         (c_top_ch),
    .next_ch     (w_lo_next),
    .wrap        (w_lo_wrap),
    .any_enabled (w_lo_any)
  );

  // Scan outputs always describe the pointer value being loaded on this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= MANUAL;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_dout_ch <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      case (r_state)
        MANUAL: begin
          r_dout    <= w_man_dout;
          r_dout_ch <= bus.sel_in;
          r_valid   <= w_man_valid;
          r_wrap    <= 1'b0;
          if (bus.mode == MODE_SCAN) begin
            r_state <= SCAN_START;
          end
        end
        SCAN_START: begin
          r_state <= SCAN;
          r_cnt   <= '0;
          r_wrap  <= 1'b0;
          // A search from the top index always wraps when it finds anything
          if (w_lo_any && w_lo_wrap) begin
            r_ptr     <= w_lo_next;
            r_dout    <= w_words[w_lo_next];
            r_dout_ch <= w_lo_next;
            r_valid   <= 1'b1;
          end else begin
            r_dout    <= '0;
            r_dout_ch <= r_ptr;
            r_valid   <= 1'b0;
          end
        end
        SCAN: begin
          if (bus.mode == MODE_MANUAL) begin
            r_state   <= MANUAL;
            r_dout    <= w_man_dout;
            r_dout_ch <= bus.sel_in;
            r_valid   <= w_man_valid;
            r_wrap    <= 1'b0;
          end else if (!w_any) begin
            r_cnt     <= '0;
            r_dout    <= '0;
            r_dout_ch <= r_ptr;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
          end else if (!w_ptr_en) begin
            // Lost channel: skip ahead at once, flag the transition word invalid
            r_ptr     <= w_next;
            r_cnt     <= '0;
            r_dout    <= w_words[w_next];
            r_dout_ch <= w_next;
            r_valid   <= 1'b0;
            r_wrap    <= w_wrap;
          end else if (bus.hold) begin
            r_dout    <= w_words[r_ptr];
            r_dout_ch <= r_ptr;
            r_valid   <= 1'b1;
            r_wrap    <= 1'b0;
          end else if (r_cnt == c_dwell_last) begin
            r_ptr     <= w_next;
            r_cnt     <= '0;
            r_dout    <= w_words[w_next];
            r_dout_ch <= w_next;
            r_valid   <= 1'b1;
            r_wrap    <= w_wrap;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_dout    <= w_words[r_ptr];
            r_dout_ch <= r_ptr;
            r_valid   <= 1'b1;
            r_wrap    <= 1'b0;
          end
        end
        default: begin
          r_state <= MANUAL;
        end
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
  assign bus.dout_valid = r_valid;
  assign bus.scan_wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tdm_mux_scanner : directed vectors for manual and scan behaviour   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_tdm_mux_scanner;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 8;
  localparam int DWELL    = 4;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] en;
    logic [7:0] exp_dout;
    logic [2:0] exp_ch;
    logic       exp_valid;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  tdm_mux_scanner_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bif ();

  tdm_mux_scanner #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [7:0] e_dout, input logic [2:0] e_ch,
                           input logic e_valid, input logic e_wrap);
    check({name, ".dout"},       32'(bif.dout),       32'(e_dout));
    check({name, ".dout_ch"},    32'(bif.dout_ch),    32'(e_ch));
    check({name, ".dout_valid"}, 32'(bif.dout_valid), 32'(e_valid));
    check({name, ".scan_wrap"},  32'(bif.scan_wrap),  32'(e_wrap));
  endtask

  initial begin
    vec_t       vecs [6];
    logic [2:0] scan_seq [4];
    logic [2:0] ch;

    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{sel: 3'd3, en: 8'hFF, exp_dout: 8'h13, exp_ch: 3'd3, exp_valid: 1'b1};
    vecs[1] = '{sel: 3'd6, en: 8'hBF, exp_dout: 8'h16, exp_ch: 3'd6, exp_valid: 1'b0};
    vecs[2] = '{sel: 3'd0, en: 8'h01, exp_dout: 8'h10, exp_ch: 3'd0, exp_valid: 1'b1};
    vecs[3] = '{sel: 3'd7, en: 8'h7F, exp_dout: 8'h17, exp_ch: 3'd7, exp_valid: 1'b0};
    vecs[4] = '{sel: 3'd7, en: 8'h80, exp_dout: 8'h17, exp_ch: 3'd7, exp_valid: 1'b1};
    vecs[5] = '{sel: 3'd1, en: 8'h00, exp_dout: 8'h11, exp_ch: 3'd1, exp_valid: 1'b0};
    scan_seq[0] = 3'd0;
    scan_seq[1] = 3'd2;
    scan_seq[2] = 3'd5;
    scan_seq[3] = 3'd7;

    rst        = 1'b1;
    bif.mode   = 1'b0;
    bif.sel_in = '0;
    bif.hold   = 1'b0;
    bif.ch_en  = '0;
    for (int k = 0; k < CHANNELS; k++) bif.din[k*WIDTH +: WIDTH] = 8'h10 + 8'(k);

    tick();
    tick();
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Manual select table
    for (int i = 0; i < 6; i++) begin
      bif.sel_in = vecs[i].sel;
      bif.ch_en  = vecs[i].en;
      tick();
      check_out($sformatf("manual[%0d]", i), vecs[i].exp_dout, vecs[i].exp_ch, vecs[i].exp_valid, 1'b0);
    end

    // Scan 0,2,5,7 with dwell 4; wrap on first return to channel 0
    bif.ch_en  = 8'hA5;
    bif.sel_in = 3'd0;
    bif.mode   = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      ch = scan_seq[(c / 4) % 4];
      check_out($sformatf("scan[%0d]", c), 8'h10 + 8'(ch), ch, 1'b1, c == 16);
    end

    // Hold on channel 2 at dwell count 1, tracking a changing source
    tick();
    check_out("scan[20]", 8'h12, 3'd2, 1'b1, 1'b0);
    tick();
    check_out("scan[21]", 8'h12, 3'd2, 1'b1, 1'b0);
    bif.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bif.din[2*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
      tick();
      check_out($sformatf("hold[%0d]", i), 8'hA0 + 8'(i), 3'd2, 1'b1, 1'b0);
    end
    bif.hold = 1'b0;
    bif.din[2*WIDTH +: WIDTH] = 8'h12;
    tick();
    check_out("resume0", 8'h12, 3'd2, 1'b1, 1'b0);
    tick();
    check_out("resume1", 8'h12, 3'd2, 1'b1, 1'b0);
    tick();
    check_out("resume2", 8'h15, 3'd5, 1'b1, 1'b0);

    // Channel 5 disabled at dwell count 1
    tick();
    check_out("ch5_cnt0", 8'h15, 3'd5, 1'b1, 1'b0);
    bif.ch_en = 8'h85;
    tick();
    check_out("skip_to7", 8'h17, 3'd7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("dwell7[%0d]", i), 8'h17, 3'd7, 1'b1, 1'b0);
    end
    tick();
    check_out("wrap_to0", 8'h10, 3'd0, 1'b1, 1'b1);

    // No channel enabled, then a single channel restored
    bif.ch_en = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("none[%0d].dout", i),      32'(bif.dout),       32'h0);
      check($sformatf("none[%0d].dout_valid", i), 32'(bif.dout_valid), 32'h0);
      check($sformatf("none[%0d].scan_wrap", i),  32'(bif.scan_wrap),  32'h0);
    end
    bif.ch_en = 8'h10;
    tick();
    check_out("reenable", 8'h14, 3'd4, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_out($sformatf("single[%0d]", k), 8'h14, 3'd4, 1'b1, (k % 4) == 0);
    end

    // Leaving scan: the very next edge samples sel_in
    bif.sel_in = 3'd3;
    bif.mode   = 1'b0;
    tick();
    check_out("to_manual", 8'h13, 3'd3, 1'b0, 1'b0);

    // Reset while parked on channel 5
    bif.ch_en = 8'hA5;
    bif.mode  = 1'b1;
    tick();
    tick();
    repeat (8) tick();
    check("prereset.dout_ch", 32'(bif.dout_ch), 32'd5);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_out("post_reset_manual", 8'h13, 3'd3, 1'b0, 1'b0);
    bif.ch_en = 8'h00;
    tick();
    check_out("post_reset_ptr", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
